// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory opcodes used by writeback, bubble and DM-write control,
// plus the state encoding of the data-memory port arbiter.
package cpu_pkg;

    localparam logic [3:0] OP_LOAD  = 4'hd;
    localparam logic [3:0] OP_STORE = 4'he;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DBG_ACC = 1'b1
    } arb_state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating 4-bit wait counter with clear, increment and limit-compare output.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] count,
    output logic       at_limit
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] count_r;

    // Count register: clear wins over increment, increment stops at LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 4'd0;
        end else if (clr) begin
            count_r <= 4'd0;
        end else if (inc && (count_r != LIMIT_C)) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign at_limit = (count_r == LIMIT_C);

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU DM stage has priority, the debug/DMA requester gets a
// one-cycle slot when the CPU is idle or after STARVE_MAX cycles of waiting.
module dm_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    cpu_op,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_r;
    arb_state_e    state_next_s;
    logic          cpu_mem_s;
    logic          cnt_clr_s;
    logic          cnt_inc_s;
    logic [3:0]    starve_cnt_s;
    logic          starve_max_s;
    logic          mem_en_s;
    logic          mem_we_s;
    logic          cpu_stall_s;
    logic          dbg_gnt_s;
    logic          dbg_read_s;
    logic [DW-1:0] dbg_rdata_r;
    logic          dbg_rvalid_r;

    assign cpu_mem_s = is_mem_op(cpu_op);

    // The counter only runs while the CPU owns the port; leaving the debug slot clears it.
    assign cnt_clr_s = (state_r == DBG_ACC) || !dbg_req;
    assign cnt_inc_s = (state_r == CPU_OWN) && dbg_req && cpu_mem_s;

    starve_counter #(
        .LIMIT (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .inc      (cnt_inc_s),
        .count    (starve_cnt_s),
        .at_limit (starve_max_s)
    );

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CPU_OWN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and port steering.
    always_comb begin
        state_next_s = state_r;
        mem_en_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        cpu_stall_s  = 1'b0;
        dbg_gnt_s    = 1'b0;
        case (state_r)
            CPU_OWN: begin
                mem_en_s = cpu_mem_s;
                mem_we_s = (cpu_op == OP_STORE);
                if (dbg_req && (!cpu_mem_s || starve_max_s)) begin
                    state_next_s = DBG_ACC;
                end else begin
                    state_next_s = CPU_OWN;
                end
            end
            DBG_ACC: begin
                mem_en_s     = 1'b1;
                mem_we_s     = dbg_we;
                mem_addr     = dbg_addr;
                mem_wdata    = dbg_wdata;
                cpu_stall_s  = cpu_mem_s;
                dbg_gnt_s    = 1'b1;
                state_next_s = CPU_OWN;
            end
            default: begin
                state_next_s = CPU_OWN;
            end
        endcase
    end

    // Reset masks every strobe so an access caught mid-grant is dropped without a write.
    assign mem_en    = !rst && mem_en_s;
    assign mem_we    = !rst && mem_we_s;
    assign cpu_stall = !rst && cpu_stall_s;
    assign dbg_gnt   = !rst && dbg_gnt_s;
    assign cpu_rdata = mem_rdata;

    assign dbg_read_s = (state_r == DBG_ACC) && !dbg_we;

    // Debug read capture at the closing edge of the debug slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rdata_r  <= '0;
            dbg_rvalid_r <= 1'b0;
        end else begin
            dbg_rvalid_r <= dbg_read_s;
            if (dbg_read_s) begin
                dbg_rdata_r <= mem_rdata;
            end else begin
                dbg_rdata_r <= dbg_rdata_r;
            end
        end
    end

    assign dbg_rdata  = dbg_rdata_r;
    assign dbg_rvalid = dbg_rvalid_r;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_dm_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    cpu_op;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory harness and reference model state.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    bit            m_grant;
    int            m_wait;
    bit            m_was_grant;
    bit            x_rvalid;
    logic [DW-1:0] x_rdata;
    bit            e_en, e_we, e_stall, e_gnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    function automatic bit is_mem(input logic [3:0] op);
        return (op == 4'hd) || (op == 4'he);
    endfunction

    // Expected combinational outputs for the current cycle.
    task automatic predict();
        e_en    = !rst && (m_grant ? 1'b1 : is_mem(cpu_op));
        e_we    = !rst && (m_grant ? dbg_we : (cpu_op == 4'he));
        e_stall = !rst && m_grant && is_mem(cpu_op);
        e_gnt   = !rst && m_grant;
        e_addr  = m_grant ? dbg_addr : cpu_addr;
        e_wdata = m_grant ? dbg_wdata : cpu_wdata;
    endtask

    // Clock edge plus model update from the inputs held during the closing cycle.
    task automatic advance();
        @(posedge clk);
        m_was_grant = 1'b0;
        if (rst) begin
            m_grant  = 1'b0;
            m_wait   = 0;
            x_rvalid = 1'b0;
            x_rdata  = '0;
        end else if (m_grant) begin
            x_rvalid = 1'b0;
            if (dbg_we) begin
                ref_mem[dbg_addr] = dbg_wdata;
            end else begin
                x_rvalid = 1'b1;
                x_rdata  = ref_mem[dbg_addr];
            end
            m_grant     = 1'b0;
            m_wait      = 0;
            m_was_grant = 1'b1;
        end else begin
            x_rvalid = 1'b0;
            if (cpu_op == 4'he) ref_mem[cpu_addr] = cpu_wdata;
            if (!dbg_req) begin
                m_wait = 0;
            end else begin
                if (!is_mem(cpu_op) || m_wait == SMAX) m_grant = 1'b1;
                if (is_mem(cpu_op) && m_wait < SMAX) m_wait = m_wait + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        cpu_op = 4'hd; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        advance();
        for (int c = 0; c < 2; c++) begin
            #2;
            n_checks++;
            if ({mem_en, mem_we, dbg_gnt, cpu_stall, dbg_rvalid} !== 5'b00000)
                $display("FAIL reset c%0d: en/we/gnt/stall/rvalid=%b expected 00000", c,
                         {mem_en, mem_we, dbg_gnt, cpu_stall, dbg_rvalid});
            else n_pass++;
            advance();
        end
        rst = 1'b0;
        #2;
        n_checks++;
        if ({mem_en, mem_we, dbg_gnt, cpu_stall} !== 4'b1000)
            $display("FAIL reset_release: en/we/gnt/stall=%b expected 1000",
                     {mem_en, mem_we, dbg_gnt, cpu_stall});
        else n_pass++;
        advance();
        dbg_req = 1'b0;
        advance();
    endtask

    task automatic test_cpu_path();
        cpu_op = 4'he; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
        #2;
        n_checks++;
        if ({mem_en, mem_we, cpu_stall} !== 3'b110 || mem_addr !== 8'h10 || mem_wdata !== 8'h5A)
            $display("FAIL cpu_store: en/we/stall=%b addr=%h data=%h expected 110 10 5a",
                     {mem_en, mem_we, cpu_stall}, mem_addr, mem_wdata);
        else n_pass++;
        advance();
        cpu_op = 4'hd;
        #2;
        n_checks++;
        if (cpu_rdata !== 8'h5A || cpu_stall !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL cpu_load: rdata=%h stall=%b we=%b expected 5a 0 0",
                     cpu_rdata, cpu_stall, mem_we);
        else n_pass++;
        advance();
    endtask

    task automatic test_idle_dbg_read();
        cpu_op = 4'h1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
        #2;
        n_checks++;
        if (dbg_gnt !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL dbgrd_c0: gnt=%b en=%b expected 0 0", dbg_gnt, mem_en);
        else n_pass++;
        advance();
        #2;
        n_checks++;
        if ({dbg_gnt, mem_en, mem_we, cpu_stall} !== 4'b1100 || mem_addr !== 8'h10)
            $display("FAIL dbgrd_c1: gnt/en/we/stall=%b addr=%h expected 1100 10",
                     {dbg_gnt, mem_en, mem_we, cpu_stall}, mem_addr);
        else n_pass++;
        advance();
        dbg_req = 1'b0;
        #2;
        n_checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 8'h5A || cpu_stall !== 1'b0 || dbg_gnt !== 1'b0)
            $display("FAIL dbgrd_c2: rvalid=%b rdata=%h stall=%b gnt=%b expected 1 5a 0 0",
                     dbg_rvalid, dbg_rdata, cpu_stall, dbg_gnt);
        else n_pass++;
        advance();
        #2;
        n_checks++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 8'h5A)
            $display("FAIL dbgrd_c3: rvalid=%b rdata=%h expected 0 5a", dbg_rvalid, dbg_rdata);
        else n_pass++;
    endtask

    task automatic test_starvation();
        cpu_op = 4'hd; cpu_addr = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'h33;
        for (int c = 0; c < 5; c++) begin
            #2;
            n_checks++;
            if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0 || dut.starve_cnt_s !== 4'(c))
                $display("FAIL starve_c%0d: gnt=%b stall=%b cnt=%0d expected 0 0 %0d",
                         c, dbg_gnt, cpu_stall, dut.starve_cnt_s, c);
            else n_pass++;
            advance();
        end
        #2;
        n_checks++;
        if ({dbg_gnt, cpu_stall, mem_we} !== 3'b111 || mem_addr !== 8'h20 || mem_wdata !== 8'h33)
            $display("FAIL starve_grant: gnt/stall/we=%b addr=%h data=%h expected 111 20 33",
                     {dbg_gnt, cpu_stall, mem_we}, mem_addr, mem_wdata);
        else n_pass++;
        advance();
        dbg_req = 1'b0; cpu_addr = 8'h20;
        #2;
        n_checks++;
        if (cpu_rdata !== 8'h33 || cpu_stall !== 1'b0 || dut.starve_cnt_s !== 4'd0)
            $display("FAIL starve_after: rdata=%h stall=%b cnt=%0d expected 33 0 0",
                     cpu_rdata, cpu_stall, dut.starve_cnt_s);
        else n_pass++;
        advance();
    endtask

    task automatic test_withdrawal();
        cpu_op = 4'hd; cpu_addr = 8'h01;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h21; dbg_wdata = 8'h77;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) dbg_req = 1'b0;
            #2;
            n_checks++;
            if (dbg_gnt !== 1'b0)
                $display("FAIL withdraw_c%0d: gnt=%b expected 0", c, dbg_gnt);
            else n_pass++;
            if (c >= 2) begin
                n_checks++;
                if (dut.starve_cnt_s !== ((c == 2) ? 4'd2 : 4'd0))
                    $display("FAIL withdraw_cnt_c%0d: cnt=%0d expected %0d", c,
                             dut.starve_cnt_s, (c == 2) ? 2 : 0);
                else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_grant();
        cpu_op = 4'h1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'hFF;
        #2;
        n_checks++;
        if (dbg_gnt !== 1'b0)
            $display("FAIL rstmid_c0: gnt=%b expected 0", dbg_gnt);
        else n_pass++;
        advance();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({mem_en, mem_we, dbg_gnt} !== 3'b000)
            $display("FAIL rstmid_c1: en/we/gnt=%b expected 000", {mem_en, mem_we, dbg_gnt});
        else n_pass++;
        advance();
        rst = 1'b0; dbg_req = 1'b0; cpu_op = 4'hd; cpu_addr = 8'h30;
        #2;
        n_checks++;
        if (cpu_rdata !== 8'h00 || dbg_rvalid !== 1'b0 || dbg_gnt !== 1'b0 || cpu_stall !== 1'b0)
            $display("FAIL rstmid_c2: rdata=%h rvalid=%b gnt=%b stall=%b expected 00 0 0 0",
                     cpu_rdata, dbg_rvalid, dbg_gnt, cpu_stall);
        else n_pass++;
        advance();
    endtask

    task automatic test_random();
        logic [3:0] ops [4];
        ops[0] = 4'hd; ops[1] = 4'he; ops[2] = 4'h1; ops[3] = 4'h7;
        for (int c = 0; c < 400; c++) begin
            cpu_op    = ops[$urandom_range(3, 0)];
            cpu_addr  = 8'($urandom_range(7, 0));
            cpu_wdata = 8'($urandom);
            if (dbg_req && m_was_grant) dbg_req = 1'b0;
            else if (dbg_req && ($urandom_range(15, 0) == 0)) dbg_req = 1'b0;
            if (!dbg_req && ($urandom_range(2, 0) == 0)) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom);
                dbg_addr  = 8'($urandom_range(7, 0));
                dbg_wdata = 8'($urandom);
            end
            predict();
            #2;
            n_checks++;
            if ({mem_en, mem_we, cpu_stall, dbg_gnt} !== {e_en, e_we, e_stall, e_gnt})
                $display("FAIL rnd_ctrl c%0d: en/we/stall/gnt=%b expected %b", c,
                         {mem_en, mem_we, cpu_stall, dbg_gnt}, {e_en, e_we, e_stall, e_gnt});
            else n_pass++;
            if (e_en) begin
                n_checks++;
                if (mem_addr !== e_addr || mem_wdata !== e_wdata || cpu_rdata !== ref_mem[e_addr])
                    $display("FAIL rnd_data c%0d: addr=%h wdata=%h rdata=%h expected %h %h %h",
                             c, mem_addr, mem_wdata, cpu_rdata, e_addr, e_wdata, ref_mem[e_addr]);
                else n_pass++;
            end
            n_checks++;
            if (dbg_rvalid !== x_rvalid || (x_rvalid && dbg_rdata !== x_rdata))
                $display("FAIL rnd_rd c%0d: rvalid=%b rdata=%h expected %b %h", c,
                         dbg_rvalid, dbg_rdata, x_rvalid, x_rdata);
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        m_grant = 1'b0; m_wait = 0; m_was_grant = 1'b0;
        x_rvalid = 1'b0; x_rdata = 8'h00;
        test_reset();
        test_cpu_path();
        test_idle_dbg_read();
        test_starvation();
        test_withdrawal();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbiter for the single data-memory port, shared between the CPU pipeline's DM stage (LOAD/STORE) and an external debug/DMA requester. The CPU has priority. A starvation counter guarantees the debug port a one-cycle grant within a bounded number of cycles, and the block stalls the pipeline whenever it takes the port away from a CPU memory op. It sits between the DM-stage pipeline register and the data memory, and `cpu_stall` feeds the PC/pipeline enable logic.

## Interface
- `AW`, default 8: address width.
- `DW`, default 8: data width.
- `STARVE_MAX`, default 4: maximum number of consecutive CPU-owned cycles a pending debug request waits before a forced grant; range 1..15.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_op` in 4: opcode of the DM-stage instruction; 4'hd = LOAD, 4'he = STORE, all others are non-memory ops.
- `cpu_addr` in AW: CPU memory address.
- `cpu_wdata` in DW: CPU store data.
- `cpu_rdata` out DW: load data to the pipeline.
- `cpu_stall` out 1: pipeline must hold its DM-stage instruction this cycle.
- `dbg_req` in 1: debug request; held with address, data and write flag until `dbg_gnt`.
- `dbg_we` in 1: debug request is a write.
- `dbg_addr` in AW: debug address.
- `dbg_wdata` in DW: debug write data.
- `dbg_gnt` out 1: debug access performed this cycle.
- `dbg_rdata` out DW: registered debug read data.
- `dbg_rvalid` out 1: one-cycle pulse; `dbg_rdata` is valid.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable, sampled at the rising edge.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: asynchronous (combinational) memory read data.

## Operation
- FSM states are CPU_OWN and DBG_ACC. Reset state is CPU_OWN.
- `cpu_mem` = (`cpu_op` == 4'hd) || (`cpu_op` == 4'he).

CPU_OWN:
- The memory port is driven combinationally from the CPU: `mem_en` = `cpu_mem`, `mem_we` = (`cpu_op` == 4'he).
- `cpu_stall` = 0 and `dbg_gnt` = 0.

Starvation counter `starve_cnt` (width 4, updated only in CPU_OWN):
- Cleared when `dbg_req` = 0.
- Incremented (saturating at STARVE_MAX) when `dbg_req` && `cpu_mem`.
- Held otherwise.

CPU_OWN transitions:
- Go to DBG_ACC if `dbg_req` && (!`cpu_mem` || `starve_cnt` == STARVE_MAX).
- Otherwise stay in CPU_OWN.

DBG_ACC:
- Lasts exactly one cycle.
- The memory port is driven from the debug side: `mem_en` = 1, `mem_we` = `dbg_we`.
- `dbg_gnt` = 1 (Moore output).
- `cpu_stall` = `cpu_mem`; the CPU memory op is not performed and is retried next cycle.
- Always returns to CPU_OWN; `starve_cnt` is cleared on exit.

Read data:
- `cpu_rdata` = `mem_rdata` at all times (combinational).
- On a DBG_ACC read, `dbg_rdata` <= `mem_rdata` and `dbg_rvalid` <= 1 at the closing edge. `dbg_rvalid` is 0 in every other cycle.
- `dbg_rdata` holds its value until the next debug read.

Other rules:
- Debug throughput is at most one access per 2 cycles; back-to-back requests pass through CPU_OWN.
- If `dbg_req` drops before grant, no access occurs and the counter clears.
- Reset: while `rst` = 1, `mem_en` = `mem_we` = 0, `cpu_stall` = 0, `dbg_gnt` = 0. State goes to CPU_OWN, `starve_cnt` = 0, `dbg_rvalid` = 0, `dbg_rdata` = 0. Reset during DBG_ACC aborts the access with no write.

## Timing
- CPU access latency is 0 cycles, with no arbitration delay when no debug grant is active. Store is committed at the rising edge; load data is combinational in the same cycle.
- Debug grant latency with the CPU idle is 1 cycle after `dbg_req` is first sampled.
- Worst-case debug grant latency under continuous CPU memory traffic is STARVE_MAX+1 cycles.
- Debug read data appears 1 cycle after `dbg_gnt`.
- Maximum CPU penalty is one stall cycle per debug grant.
- `cpu_stall` and the `mem_*` outputs are combinational from state and `cpu_op`. `dbg_gnt` is decoded from state only.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode constants OP_LOAD = 4'hd and OP_STORE = 4'he (shared with the writeback, bubble and DM-write control).
  - The arbiter state encoding (CPU_OWN = 1'b0, DBG_ACC = 1'b1).
- Sub-module `starve_counter`: a saturating 4-bit counter with clear, increment, limit-compare output and synchronous reset. Everything else is in the top module.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `dbg_req` = 1 and `cpu_op` = 4'hd → `mem_en` = 0, `dbg_gnt` = 0, `cpu_stall` = 0, `dbg_rvalid` = 0. The first cycle after release is CPU_OWN and the load proceeds.
- CPU path: STORE 0x10 ← 0x5A, then LOAD 0x10 with no debug traffic → `mem_we` = 1 in cycle 0; `cpu_rdata` = 0x5A in cycle 1; `cpu_stall` never asserted.
- Idle-CPU debug read: `cpu_op` = 4'h1, `dbg_req` read 0x10 at cycle 0 → `dbg_gnt` in cycle 1; `dbg_rvalid` = 1 with `dbg_rdata` = 0x5A in cycle 2; `cpu_stall` = 0 throughout.
- Starvation: continuous CPU LOADs, STARVE_MAX = 4, debug write 0x20 ← 0x33 requested at cycle 0 → `starve_cnt` counts 1..4; `dbg_gnt` and `cpu_stall` = 1 in cycle 5 only. A later CPU LOAD 0x20 returns 0x33.
- Withdrawal: `dbg_req` high for cycles 0-1 under CPU LOAD traffic, then low → no `dbg_gnt`; `starve_cnt` = 0 at cycle 3.
- Reset mid-grant: assert `rst` in the DBG_ACC cycle of a debug write 0x30 ← 0xFF → `mem_we` = 0 in that cycle; memory 0x30 is unchanged; the next cycle is CPU_OWN with `dbg_rvalid` = 0.
